// File: rtl/pio_input_conditioner_if.sv
// Board-input conditioner bus bundle.
// Raw/clear in from the board side, clean data and edge flags out.
interface pio_input_conditioner_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clear_edges;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] edge_capture;
  logic             edge_irq;

  modport master (
    output raw_in,
    output clear_edges,
    input  out_data,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_capture,
    input  edge_irq
  );

  modport slave (
    input  raw_in,
    input  clear_edges,
    output out_data,
    output rise_pulse,
    output fall_pulse,
    output edge_capture,
    output edge_irq
  );
endinterface

// File: rtl/pio_input_conditioner.sv
// Per-bit 2-flop sync + counter debounce for the input PIO,
// with rise/fall pulses and sticky W1C rising-edge capture.
module pio_input_conditioner #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_input_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic             irq_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Debounce: accept s2 once it has disagreed for the full window.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != out_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          out_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = out_d & ~out_q;
    fall_d = out_q & ~out_d;
    // A new rise beats a simultaneous clear.
    cap_d  = (cap_q & ~bus.clear_edges) | rise_d;
  end

  // Sync chain, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= bus.raw_in;
      s2_q   <= s1_q;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cap_q  <= cap_d;
      irq_q  <= |cap_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.out_data     = out_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.edge_capture = cap_q;
  assign bus.edge_irq     = irq_q;

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Bench for pio_input_conditioner: directed scenarios plus
// random traffic against a sliding-window reference model.
module tb_pio_input_conditioner;

  localparam int W = 10;
  localparam int D = 4;
  localparam int CW = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pio_input_conditioner_if #(.WIDTH(W)) bus ();

  pio_input_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit takes the synchronized value once the
  // last D samples since reset all differ from the current level.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_cap;
  logic         m_irq;
  logic [W-1:0] hist [$];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] upd;
    logic [W-1:0] nout;
    logic         all;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      m_rise = '0; m_fall = '0; m_cap = '0;
      m_irq = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      upd = '0;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          all = 1'b1;
          foreach (hist[j]) if (hist[j][b] == m_out[b]) all = 1'b0;
          upd[b] = all;
        end
      end
      nout   = m_out ^ upd;
      m_rise = upd & nout;
      m_fall = upd & ~nout;
      m_cap  = (m_cap & ~bus.clear_edges) | m_rise;
      m_irq  = |m_cap;
      m_out  = nout;
      m_s2   = m_s1;
      m_s1   = bus.raw_in;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    @(negedge clk);
    bus.raw_in = raw;
    bus.clear_edges = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    @(negedge clk);
    bus.raw_in = '1;
    bus.clear_edges = '0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_data, bus.rise_pulse, bus.fall_pulse,
         bus.edge_capture, bus.edge_irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_async out=%h cap=%h irq=%b want 0",
               bus.out_data, bus.edge_capture, bus.edge_irq);
    end
    step();
    step();
    n_tests++;
    if ({bus.out_data, bus.edge_capture, bus.edge_irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold out=%h cap=%h want 0",
               bus.out_data, bus.edge_capture);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int e = 1; e <= D + 4; e++) begin
      step();
      if (seen == 0 && bus.out_data == '1) seen = e;
      if (e == D + 2) begin
        n_tests++;
        if (bus.rise_pulse !== 10'h3FF || bus.edge_capture !== 10'h3FF
            || bus.edge_irq !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_powerup rise=%h cap=%h irq=%b want 3ff/3ff/1",
                   bus.rise_pulse, bus.edge_capture, bus.edge_irq);
        end
      end
      if (e == D + 3) begin
        n_tests++;
        if (bus.rise_pulse !== '0) begin
          n_fail++;
          $display("FAIL reset_pulse_width rise=%h want 000",
                   bus.rise_pulse);
        end
      end
    end
    n_tests++;
    if (seen != D + 2) begin
      n_fail++;
      $display("FAIL reset_latency edges=%0d want %0d", seen, D + 2);
    end
  endtask

  task automatic test_clean_edge();
    do_reset('0);
    for (int e = 0; e < D + 4; e++) step();
    bus.raw_in[0] = 1'b1;
    for (int e = 1; e <= D + 2; e++) begin
      step();
      if (e == D) begin
        n_tests++;
        if (bus.out_data[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_early out0=%b want 0", bus.out_data[0]);
        end
      end
    end
    n_tests++;
    if (bus.out_data !== 10'h001 || bus.rise_pulse !== 10'h001) begin
      n_fail++;
      $display("FAIL clean_update out=%h rise=%h want 001/001",
               bus.out_data, bus.rise_pulse);
    end
    step();
    n_tests++;
    if (bus.rise_pulse !== '0 || bus.edge_capture !== 10'h001
        || bus.edge_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_after rise=%h cap=%h irq=%b want 000/001/1",
               bus.rise_pulse, bus.edge_capture, bus.edge_irq);
    end
  endtask

  task automatic test_glitch();
    logic bad;
    do_reset('0);
    for (int e = 0; e < D + 4; e++) step();
    bad = 1'b0;
    bus.raw_in[3] = 1'b1;
    for (int e = 0; e < D - 1; e++) step();
    bus.raw_in[3] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (bus.out_data !== '0 || bus.rise_pulse !== '0
          || bus.fall_pulse !== '0 || bus.edge_capture !== '0)
        bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL glitch_reject out=%h cap=%h want 000/000",
               bus.out_data, bus.edge_capture);
    end
    // A glitch must not leave a partial count behind.
    bus.raw_in[3] = 1'b1;
    for (int e = 0; e < D + 1; e++) step();
    n_tests++;
    if (bus.out_data[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_count_cleared out3=%b want 0",
               bus.out_data[3]);
    end
    step();
    n_tests++;
    if (bus.out_data[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_then_clean out3=%b want 1", bus.out_data[3]);
    end
  endtask

  task automatic test_bounce();
    int rises, falls, at;
    do_reset('0);
    for (int e = 0; e < D + 4; e++) step();
    rises = 0; falls = 0; at = 0;
    for (int c = 0; c < 20; c++) begin
      bus.raw_in[5] = ((c / 2) % 2 == 0);
      step();
      rises += int'(bus.rise_pulse[5]);
      falls += int'(bus.fall_pulse[5]);
    end
    bus.raw_in[5] = 1'b1;
    for (int e = 1; e <= D + 6; e++) begin
      step();
      rises += int'(bus.rise_pulse[5]);
      falls += int'(bus.fall_pulse[5]);
      if (at == 0 && bus.out_data[5] === 1'b1) at = e;
    end
    n_tests++;
    if (rises != 1 || falls != 0) begin
      n_fail++;
      $display("FAIL bounce_pulses rise=%0d fall=%0d want 1/0",
               rises, falls);
    end
    n_tests++;
    if (at != D + 2) begin
      n_fail++;
      $display("FAIL bounce_latency edges=%0d want %0d", at, D + 2);
    end
  endtask

  task automatic test_clear_race();
    do_reset('0);
    for (int e = 0; e < D + 4; e++) step();
    bus.raw_in[0] = 1'b1;
    for (int e = 0; e < D + 3; e++) step();
    bus.clear_edges = 10'h001;
    step();
    bus.clear_edges = '0;
    n_tests++;
    if (bus.edge_capture !== '0 || bus.edge_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_plain cap=%h irq=%b want 000/0",
               bus.edge_capture, bus.edge_irq);
    end
    bus.raw_in[0] = 1'b0;
    for (int e = 0; e < D + 2; e++) step();
    n_tests++;
    if (bus.fall_pulse !== 10'h001 || bus.edge_capture !== '0
        || bus.out_data[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_no_capture fall=%h cap=%h want 001/000",
               bus.fall_pulse, bus.edge_capture);
    end
    bus.raw_in[0] = 1'b1;
    for (int e = 0; e < D + 1; e++) step();
    bus.clear_edges = 10'h001;
    step();
    bus.clear_edges = '0;
    n_tests++;
    if (bus.rise_pulse[0] !== 1'b1 || bus.edge_capture[0] !== 1'b1
        || bus.edge_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_race rise0=%b cap0=%b irq=%b want 1/1/1",
               bus.rise_pulse[0], bus.edge_capture[0], bus.edge_irq);
    end
  endtask

  task automatic test_reset_midcount();
    int at;
    do_reset('0);
    for (int e = 0; e < D + 4; e++) step();
    bus.raw_in[2] = 1'b1;
    for (int e = 0; e < D; e++) step();
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if (bus.out_data[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_reset out2=%b want 0", bus.out_data[2]);
    end
    rst_n = 1'b1;
    at = 0;
    for (int e = 1; e <= D + 4; e++) begin
      step();
      if (at == 0 && bus.out_data[2] === 1'b1) at = e;
    end
    n_tests++;
    if (at != D + 2) begin
      n_fail++;
      $display("FAIL midcount_latency edges=%0d want %0d", at, D + 2);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset(W'($urandom));
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(5) == 0) bus.raw_in[b] = ~bus.raw_in[b];
      bus.clear_edges = ($urandom_range(3) == 0) ? W'($urandom) : '0;
      if (c == 300) rst_n = 1'b0;
      if (c == 302) rst_n = 1'b1;
      step();
      n_tests++;
      if (bus.out_data !== m_out || bus.rise_pulse !== m_rise
          || bus.fall_pulse !== m_fall || bus.edge_capture !== m_cap
          || bus.edge_irq !== m_irq) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random c=%0d out=%h/%h rise=%h/%h fall=%h/%h cap=%h/%h irq=%b/%b (got/want)",
                   c, bus.out_data, m_out, bus.rise_pulse, m_rise,
                   bus.fall_pulse, m_fall, bus.edge_capture, m_cap,
                   bus.edge_irq, m_irq);
        bad++;
      end
    end
    bus.clear_edges = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.raw_in = '0;
    bus.clear_edges = '0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_bounce();
    test_clear_race();
    test_reset_midcount();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
